// File: rtl/fir_stream_dma.sv
// fir_stream_dma: memory-to-stream DMA wrapped around the FIR core.
// Reads `length` words from src_base, streams them out on ss_*, collects
// the FIR results from sm_* and writes them back to dst_base. Both
// directions share one memory request port with one request in flight.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, src_base, dst_base, length   transfer launch and setup
//   busy, done, err            status (err sticky until next start)
//   mem_addr/rw/req/wdata, mem_ack/rdata   shared memory request port
//   ss_tvalid/tdata/tlast, ss_tready       samples to the FIR core
//   sm_tvalid/tdata/tlast, sm_tready       results from the FIR core
//
// Optional build macro FIR_DMA_TLAST_CHECK_EN: flags sm_tlast placement
// errors in err. Without it sm_tlast is ignored and err stays 0.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | transfer active, issuing reads/writes
module fir_stream_dma #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_base,
  input  logic [31:0]      dst_base,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      mem_addr,
  output logic             mem_rw,
  output logic             mem_req,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             ss_tvalid,
  output logic [31:0]      ss_tdata,
  output logic             ss_tlast,
  input  logic             ss_tready,
  input  logic             sm_tvalid,
  input  logic [31:0]      sm_tdata,
  input  logic             sm_tlast,
  output logic             sm_tready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;

  logic [29:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d, rd_idx_q, rd_idx_d, ss_idx_q, ss_idx_d;
  logic [LEN_W-1:0] sm_idx_q, sm_idx_d, wr_idx_q, wr_idx_d;
  logic             req_q, req_d, rw_q, rw_d, done_q, done_d;
  logic             busy_q, busy_d, err_q, err_d, live_q;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;

  logic [31:0]      rf_mem [FIFO_DEPTH];
  logic [31:0]      wf_mem [FIFO_DEPTH];
  logic [PW-1:0]    rf_wp_q, rf_rp_q, wf_wp_q, wf_rp_q;
  logic [PW:0]      rf_cnt_q, wf_cnt_q;

  logic start_ok, rd_ack, wr_ack, last_wr, sm_fire;
  logic rf_push, rf_pop, wf_push, wf_pop;

  logic [3:0] unused_lsb;
  assign unused_lsb = {src_base[1:0], dst_base[1:0]};

  function automatic logic [31:0] word_off(input logic [LEN_W-1:0] idx);
    word_off = {{(30-LEN_W){1'b0}}, idx, 2'b00};
  endfunction

  assign start_ok = (state_q == IDLE) && start && (length != '0);
  assign rd_ack   = (state_q == RUN) && req_q && mem_ack && !rw_q;
  assign wr_ack   = (state_q == RUN) && req_q && mem_ack && rw_q;
  assign last_wr  = wr_ack && ((wr_idx_q + LEN_W'(1)) == len_q);
  assign sm_fire  = sm_tvalid && sm_tready;

  assign rf_push = rd_ack;
  assign rf_pop  = ss_tvalid && ss_tready;
  // Beats past `length` are handshaken but never stored.
  assign wf_push = sm_fire && (state_q == RUN) && (sm_idx_q < len_q);
  assign wf_pop  = wr_ack;

  assign ss_tvalid = (rf_cnt_q != '0);
  assign ss_tdata  = ss_tvalid ? rf_mem[rf_rp_q] : '0;
  assign ss_tlast  = ss_tvalid && (ss_idx_q == (len_q - LEN_W'(1)));
  assign sm_tready = live_q && (wf_cnt_q != DEPTH_C);

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = req_q;
  assign mem_rw    = rw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    rd_idx_d = rd_idx_q;
    ss_idx_d = ss_idx_q;
    sm_idx_d = sm_idx_q;
    wr_idx_d = wr_idx_q;
    req_d    = req_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            // First read goes out straight from the start cycle.
            state_d  = RUN;
            src_d    = src_base[31:2];
            dst_d    = dst_base[31:2];
            len_d    = length;
            rd_idx_d = LEN_W'(1);
            ss_idx_d = '0;
            sm_idx_d = '0;
            wr_idx_d = '0;
            err_d    = 1'b0;
            req_d    = 1'b1;
            rw_d     = 1'b0;
            addr_d   = {src_base[31:2], 2'b00};
          end
        end
      end
      RUN: begin
        if (rf_pop) ss_idx_d = ss_idx_q + LEN_W'(1);
        if (wf_push) sm_idx_d = sm_idx_q + LEN_W'(1);
`ifdef FIR_DMA_TLAST_CHECK_EN
        if (sm_fire && (sm_tlast != (sm_idx_q == (len_q - LEN_W'(1))))) err_d = 1'b1;
`endif
        if (req_q) begin
          if (mem_ack) begin
            req_d = 1'b0;
            if (rw_q) begin
              wr_idx_d = wr_idx_q + LEN_W'(1);
              if (last_wr) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end else if (wf_cnt_q != '0) begin
          // Draining results first keeps a full FIR pipeline from deadlocking.
          req_d   = 1'b1;
          rw_d    = 1'b1;
          addr_d  = {dst_q, 2'b00} + word_off(wr_idx_q);
          wdata_d = wf_mem[wf_rp_q];
        end else if ((rd_idx_q < len_q) && (rf_cnt_q != DEPTH_C)) begin
          req_d    = 1'b1;
          rw_d     = 1'b0;
          addr_d   = {src_q, 2'b00} + word_off(rd_idx_q);
          rd_idx_d = rd_idx_q + LEN_W'(1);
        end
      end
    endcase
    // busy stays high through the done cycle of a real transfer.
    busy_d = (state_d == RUN) || last_wr;
  end

`ifndef FIR_DMA_TLAST_CHECK_EN
  logic unused_tlast;
  assign unused_tlast = sm_tlast;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      rd_idx_q <= '0;
      ss_idx_q <= '0;
      sm_idx_q <= '0;
      wr_idx_q <= '0;
      req_q    <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
      rf_wp_q  <= '0;
      rf_rp_q  <= '0;
      rf_cnt_q <= '0;
      wf_wp_q  <= '0;
      wf_rp_q  <= '0;
      wf_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      rd_idx_q <= rd_idx_d;
      ss_idx_q <= ss_idx_d;
      sm_idx_q <= sm_idx_d;
      wr_idx_q <= wr_idx_d;
      req_q    <= req_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      live_q   <= 1'b1;
      if (start_ok) begin
        rf_wp_q  <= '0;
        rf_rp_q  <= '0;
        rf_cnt_q <= '0;
        wf_wp_q  <= '0;
        wf_rp_q  <= '0;
        wf_cnt_q <= '0;
      end else begin
        if (rf_push) rf_wp_q <= rf_wp_q + PW'(1);
        if (rf_pop)  rf_rp_q <= rf_rp_q + PW'(1);
        if (wf_push) wf_wp_q <= wf_wp_q + PW'(1);
        if (wf_pop)  wf_rp_q <= wf_rp_q + PW'(1);
        rf_cnt_q <= rf_cnt_q + {{PW{1'b0}}, rf_push} - {{PW{1'b0}}, rf_pop};
        wf_cnt_q <= wf_cnt_q + {{PW{1'b0}}, wf_push} - {{PW{1'b0}}, wf_pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rf_push) rf_mem[rf_wp_q] <= mem_rdata;
    if (wf_push) wf_mem[wf_wp_q] <= sm_tdata;
  end

endmodule

// File: tb/tb_fir_stream_dma.sv
module tb_fir_stream_dma;
  localparam int FD = 4;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   src_base = '0, dst_base = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done, err, mem_rw, mem_req, ss_tvalid, ss_tlast, sm_tready;
  logic [31:0]   mem_addr, mem_wdata, ss_tdata;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          ss_tready = 1'b1, sm_tvalid = 1'b0, sm_tlast = 1'b0;
  logic [31:0]   sm_tdata = '0;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_rd[$];
  logic [63:0] exp_wr[$];
  logic [32:0] exp_ss[$];
  logic [31:0] fir_q[$];
  logic [31:0] e_rd;
  logic [63:0] e_wr;
  logic [32:0] e_ss;
  int out_idx = 0, tlast_beat = 0, rd_issued = 0, done_cnt = 0, age = 0;
  logic ss_fire_n = 1'b0, sm_fire_n = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] cap_addr = '0;

  always #5 clk = ~clk;

  fir_stream_dma #(.FIFO_DEPTH(FD), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
    .length(length), .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_rw(mem_rw), .mem_req(mem_req), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .ss_tready(ss_tready), .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .sm_tready(sm_tready)
  );

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, expv);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got=unexpected beat want=none", name);
  endtask

  // Monitor: compares every request rise and stream beat against the queues.
  always @(negedge clk) begin
    ss_fire_n = ss_tvalid && ss_tready;
    sm_fire_n = sm_tvalid && sm_tready;
    if (done) done_cnt++;
    if (prev_ack) chk("req_drop_after_ack", mem_req, 0);
    if (mem_req && !prev_req) begin
      cap_addr = mem_addr;
      if (mem_rw) begin
        if (exp_wr.size() == 0) unexpected("wr_req");
        else begin
          e_wr = exp_wr.pop_front();
          chk("wr_addr", mem_addr, e_wr[63:32]);
          chk("wr_data", mem_wdata, e_wr[31:0]);
        end
      end else begin
        rd_issued++;
        if (exp_rd.size() == 0) unexpected("rd_req");
        else begin
          e_rd = exp_rd.pop_front();
          chk("rd_addr", mem_addr, e_rd);
        end
      end
    end
    if (mem_req && mem_ack) chk("addr_hold", mem_addr, cap_addr);
    if (ss_fire_n) begin
      fir_q.push_back(ss_tdata);
      if (exp_ss.size() == 0) unexpected("ss_beat");
      else begin
        e_ss = exp_ss.pop_front();
        chk("ss_beat", {ss_tlast, ss_tdata}, e_ss);
      end
    end
    prev_req = mem_req;
    prev_ack = mem_ack && mem_req;
  end

  // Memory: ack one cycle after the request is seen.
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      mem_ack = 1'b0;
      age = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      age = 0;
    end else if (mem_req) begin
      age++;
      if (age > 1) begin
        mem_ack = 1'b1;
        mem_rdata = mem_rw ? 32'h0 : rd_pat(mem_addr);
      end
    end
  end

  // Identity FIR: replays accepted ss samples on sm.
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      sm_tvalid = 1'b0;
      sm_tlast = 1'b0;
    end else begin
      if (sm_fire_n && fir_q.size() != 0) begin
        void'(fir_q.pop_front());
        out_idx++;
      end
      if (fir_q.size() != 0) begin
        sm_tvalid = 1'b1;
        sm_tdata = fir_q[0];
        sm_tlast = (out_idx == tlast_beat);
      end else begin
        sm_tvalid = 1'b0;
        sm_tlast = 1'b0;
      end
    end
  end

  task automatic push_exp(input logic [31:0] src, input logic [31:0] dst, input int len);
    logic [31:0] a, w;
    for (int i = 0; i < len; i++) begin
      a = {src[31:2], 2'b00} + 32'(4 * i);
      w = {dst[31:2], 2'b00} + 32'(4 * i);
      exp_rd.push_back(a);
      exp_ss.push_back({(i == len - 1), rd_pat(a)});
      exp_wr.push_back({w, rd_pat(a)});
    end
  endtask

  task automatic pulse_start(input logic [31:0] src, input logic [31:0] dst, input int len);
    @(posedge clk); #1;
    start = 1'b1;
    src_base = src;
    dst_base = dst;
    length = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int tl_beat, input int stall);
    int dc, cyc;
    logic exp_err;
`ifdef FIR_DMA_TLAST_CHECK_EN
    exp_err = (tl_beat != len - 1);
`else
    exp_err = 1'b0;
`endif
    push_exp(src, dst, len);
    tlast_beat = tl_beat;
    out_idx = 0;
    rd_issued = 0;
    dc = done_cnt;
    if (stall > 0) ss_tready = 1'b0;
    pulse_start(src, dst, len);
    chk("busy_after_start", busy, 1);
    chk("req_after_start", mem_req, 1);
    chk("err_cleared", err, 0);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      chk("reads_while_stalled", rd_issued, FD);
      ss_tready = 1'b1;
    end
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", done, 1);
    chk("busy_in_done_cycle", busy, 1);
    @(posedge clk); #1;
    chk("done_single_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("done_count", done_cnt - dc, 1);
    chk("rd_left", exp_rd.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
    chk("ss_left", exp_ss.size(), 0);
    chk("err_final", err, exp_err);
  endtask

  initial begin
    int dc, ri, cyc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_rw", mem_rw, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ss_tvalid", ss_tvalid, 0);
    chk("rst_ss_tlast", ss_tlast, 0);
    chk("rst_ss_tdata", ss_tdata, 0);
    chk("rst_sm_tready", sm_tready, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("sm_tready_live", sm_tready, 1);

    // basic
    run_xfer(32'h0000_0100, 32'h0000_0200, 4, 3, 0);
    // backpressure
    run_xfer(32'h0000_0400, 32'h0000_0800, 8, 7, 20);

    // zero length
    dc = done_cnt;
    ri = rd_issued;
    pulse_start(32'h0000_0500, 32'h0000_0900, 0);
    chk("zl_done", done, 1);
    chk("zl_busy", busy, 0);
    chk("zl_req", mem_req, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("zl_done_count", done_cnt - dc, 1);
    chk("zl_no_reads", rd_issued - ri, 0);
    chk("zl_busy_later", busy, 0);

    // wrap (source bits [1:0] also ignored)
    run_xfer(32'hFFFF_FFFB, 32'h0000_1000, 3, 2, 0);

    // reset while a write is outstanding
    push_exp(32'h0000_0300, 32'h0000_0700, 4);
    tlast_beat = 3;
    out_idx = 0;
    pulse_start(32'h0000_0300, 32'h0000_0700, 4);
    cyc = 0;
    while (!(mem_req && mem_rw) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_saw_write", mem_req && mem_rw, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ss_tvalid", ss_tvalid, 0);
    chk("arst_sm_tready", sm_tready, 0);
    exp_rd.delete();
    exp_wr.delete();
    exp_ss.delete();
    fir_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);
    run_xfer(32'h0000_2000, 32'h0000_3000, 5, 4, 0);

`ifdef FIR_DMA_TLAST_CHECK_EN
    run_xfer(32'h0000_0100, 32'h0000_0600, 4, 2, 0);
    run_xfer(32'h0000_0100, 32'h0000_0600, 4, 3, 0);
`else
    run_xfer(32'h0000_0100, 32'h0000_0600, 4, 1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
